ctlr_mem_responder: RTL and testbench



---
 rtl/ctlr_mem_responder.sv | 97 +++++++++
 tb/tb_ctlr_mem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctlr_mem_responder.sv
// Memory-side responder for dcache miss/writeback traffic: tags each accepted LOAD/STORE, completes it in order.
// Latency: fixed LATENCY cycles from acceptance to Ctlr2proc_tag/Ctlr2proc_data; the completion pipeline never stalls.
// Backpressure: response 0 while MAX_OUTSTANDING tags are busy; the requester holds its command and retries.
module ctlr_mem_responder #(
    parameter int LATENCY         = 4,
    parameter int MEM_WORDS       = 1024,
    parameter int MAX_OUTSTANDING = 15,
    parameter int XLEN            = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      dcache2ctlr_command,
    input  logic [XLEN-1:0] dcache2ctlr_addr,
    input  logic [63:0]     dcache2ctlr_data,
    output logic [3:0]      Ctlr2proc_response,
    output logic [63:0]     Ctlr2proc_data,
    output logic [3:0]      Ctlr2proc_tag
);
    localparam int         IDX_W     = $clog2(MEM_WORDS);
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [3:0] MAX_OUT   = 4'(MAX_OUTSTANDING);

    typedef struct packed {
        logic        vld;
        logic [3:0]  tag;
        logic [63:0] dat;
    } rec_t;

    logic [63:0]      mem [MEM_WORDS];
    rec_t             pipe [LATENCY];
    rec_t             in_rec;
    rec_t             done;
    logic [15:1]      busy;
    logic [3:0]       outstanding;
    logic [3:0]       free_tag;
    logic [IDX_W-1:0] idx;
    logic             is_load;
    logic             is_store;
    logic             accept;
    logic             unused_addr_bits;

    assign idx              = dcache2ctlr_addr[3+IDX_W-1:3];
    assign unused_addr_bits = ^{dcache2ctlr_addr[XLEN-1:3+IDX_W], dcache2ctlr_addr[2:0]};
    assign is_load          = (dcache2ctlr_command == BUS_LOAD);
    assign is_store         = (dcache2ctlr_command == BUS_STORE);
    assign accept           = (is_load || is_store) && !reset && (outstanding < MAX_OUT);

    // Lowest-numbered free tag; outstanding < MAX_OUT <= 15 guarantees one exists on accept.
    always_comb begin
        free_tag = '0;
        for (int t = 15; t >= 1; t--) begin
            if (!busy[t]) free_tag = 4'(t);
        end
    end

    always_comb begin
        in_rec = '0;
        if (accept) begin
            in_rec.vld = 1'b1;
            in_rec.tag = free_tag;
            in_rec.dat = is_load ? mem[idx] : 64'd0;
        end
    end

    assign done               = pipe[LATENCY-1];
    assign Ctlr2proc_response = accept ? free_tag : 4'd0;
    assign Ctlr2proc_tag      = done.vld ? done.tag : 4'd0;
    assign Ctlr2proc_data     = done.vld ? done.dat : 64'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else if (accept && is_store) begin
            mem[idx] <= dcache2ctlr_data;
        end
    end

    // Release and allocate never touch the same tag: the completing tag is still busy this cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
            busy        <= '0;
            outstanding <= '0;
        end else begin
            pipe[0] <= in_rec;
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
            if (done.vld) busy[done.tag] <= 1'b0;
            if (accept)   busy[free_tag] <= 1'b1;
            outstanding <= outstanding + {3'd0, accept} - {3'd0, done.vld};
        end
    end

    busy_count_matches : assert property (@(posedge clock) disable iff (reset)
        $countones(busy) == int'(outstanding));

endmodule

// File: tb/tb_ctlr_mem_responder.sv
// Randomized and directed bench for ctlr_mem_responder with a tag/memory reference model.
module tb_ctlr_mem_responder;
    localparam int LAT  = 4;
    localparam int MAXO = 15;
    localparam int WORDS = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cmd = 2'd0;
    logic [1:0]  bp_cmd = 2'd0;
    logic [63:0] addr = 64'd0;
    logic [63:0] wdata = 64'd0;
    logic [3:0]  resp, tag, bp_resp, bp_tag;
    logic [63:0] rdata, bp_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: cycle from which each tag may be handed out again, completions keyed by cycle, sparse memory.
    int          free_at [16];
    logic [3:0]  comp_tag [int];
    logic [63:0] comp_dat [int];
    logic [63:0] mem_m [int];

    always #5 clock = ~clock;

    ctlr_mem_responder #(.LATENCY(LAT), .MEM_WORDS(WORDS), .MAX_OUTSTANDING(MAXO), .XLEN(64)) dut (
        .clock(clock), .reset(reset),
        .dcache2ctlr_command(cmd), .dcache2ctlr_addr(addr), .dcache2ctlr_data(wdata),
        .Ctlr2proc_response(resp), .Ctlr2proc_data(rdata), .Ctlr2proc_tag(tag)
    );

    ctlr_mem_responder #(.LATENCY(8), .MEM_WORDS(WORDS), .MAX_OUTSTANDING(2), .XLEN(64)) dut_bp (
        .clock(clock), .reset(reset),
        .dcache2ctlr_command(bp_cmd), .dcache2ctlr_addr(addr), .dcache2ctlr_data(wdata),
        .Ctlr2proc_response(bp_resp), .Ctlr2proc_data(bp_rdata), .Ctlr2proc_tag(bp_tag)
    );

    task automatic model_reset();
        for (int t = 0; t < 16; t++) free_at[t] = 0;
        comp_tag.delete();
        comp_dat.delete();
        mem_m.delete();
    endtask

    // One cycle on the main DUT: drive, check at negedge against the model, update the model.
    task automatic step(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d);
        int          outst;
        int          widx;
        logic [3:0]  er;
        logic [3:0]  et;
        logic [63:0] ed;
        cmd = c; addr = a; wdata = d;
        @(negedge clock);
        widx = int'((a >> 3) % 64'(WORDS));
        outst = 0;
        for (int t = 1; t < 16; t++) if (free_at[t] > cyc) outst++;
        er = 4'd0;
        if ((c == 2'd1 || c == 2'd2) && outst < MAXO) begin
            for (int t = 15; t >= 1; t--) if (free_at[t] <= cyc) er = 4'(t);
        end
        et = comp_tag.exists(cyc) ? comp_tag[cyc] : 4'd0;
        ed = comp_dat.exists(cyc) ? comp_dat[cyc] : 64'd0;
        checks++;
        if (resp !== er) begin
            failures++;
            $display("FAIL resp cycle %0d cmd %0d: got %0d expected %0d", cyc, c, resp, er);
        end
        checks++;
        if (tag !== et) begin
            failures++;
            $display("FAIL tag cycle %0d: got %0d expected %0d", cyc, tag, et);
        end
        checks++;
        if (rdata !== ed) begin
            failures++;
            $display("FAIL data cycle %0d: got %h expected %h", cyc, rdata, ed);
        end
        if (er != 4'd0) begin
            free_at[er] = cyc + LAT + 1;
            comp_tag[cyc + LAT] = er;
            comp_dat[cyc + LAT] = (c == 2'd1 && mem_m.exists(widx)) ? mem_m[widx] : 64'd0;
            if (c == 2'd2) mem_m[widx] = d;
        end
        @(posedge clock); #1;
        cyc++;
    endtask

    task automatic drain();
        repeat (LAT + 2) step(2'd0, 64'd0, 64'd0);
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd = 2'd1; bp_cmd = 2'd1; addr = 64'h100; wdata = 64'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (resp !== 4'd0 || bp_resp !== 4'd0) begin
            failures++;
            $display("FAIL reset_resp: got %0d/%0d expected 0/0", resp, bp_resp);
        end
        checks++;
        if (tag !== 4'd0 || rdata !== 64'd0) begin
            failures++;
            $display("FAIL reset_out: got tag %0d data %h expected 0/0", tag, rdata);
        end
        cmd = 2'd0; bp_cmd = 2'd0;
        reset = 1'b0;
        @(posedge clock); #1;
        model_reset();
        cyc = 0;
    endtask

    task automatic test_backpressure();
        logic [3:0] er;
        logic [3:0] et;
        cmd = 2'd0; bp_cmd = 2'd1; addr = 64'h40; wdata = 64'd0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            er = (i == 0 || i == 9) ? 4'd1 : (i == 1 || i == 10) ? 4'd2 : 4'd0;
            et = (i == 8) ? 4'd1 : (i == 9) ? 4'd2 : 4'd0;
            checks++;
            if (bp_resp !== er) begin
                failures++;
                $display("FAIL bp_resp offset %0d: got %0d expected %0d", i, bp_resp, er);
            end
            checks++;
            if (bp_tag !== et || bp_rdata !== 64'd0) begin
                failures++;
                $display("FAIL bp_tag offset %0d: got %0d/%h expected %0d/0", i, bp_tag, bp_rdata, et);
            end
            @(posedge clock); #1;
            cyc++;
        end
        bp_cmd = 2'd0;
    endtask

    task automatic test_single_load();
        step(2'd0, 64'd0, 64'd0);
        step(2'd1, 64'h100, 64'd0);
        drain();
    endtask

    task automatic test_store_load();
        step(2'd2, 64'h108, 64'hDEADBEEF_CAFEF00D);
        step(2'd1, 64'h108, 64'd0);
        step(2'd1, 64'h10C, 64'd0);
        drain();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) step(2'd1, 64'(i * 8), 64'd0);
        drain();
    endtask

    task automatic test_alias_invalid();
        step(2'd2, 64'h2000, 64'h55);
        step(2'd3, 64'h0, 64'hFFFF);
        step(2'd1, 64'h0, 64'd0);
        step(2'd3, 64'h8, 64'h1234);
        step(2'd1, 64'h8, 64'd0);
        drain();
    endtask

    task automatic test_random();
        logic [1:0]  c;
        logic [63:0] a;
        logic [63:0] d;
        int          r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            c = (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : (r < 8) ? 2'd3 : 2'd0;
            a = {32'($urandom), 32'($urandom)};
            a[12:3] = 10'($urandom_range(0, 15));
            d = {32'($urandom), 32'($urandom)};
            step(c, a, d);
        end
        drain();
    endtask

    task automatic test_midflight_reset();
        step(2'd2, 64'h80, 64'h1111_2222_3333_4444);
        step(2'd1, 64'h80, 64'd0);
        step(2'd1, 64'h88, 64'd0);
        step(2'd1, 64'h90, 64'd0);
        cmd = 2'd1; addr = 64'h80;
        reset = 1'b1;
        #2;
        checks++;
        if (resp !== 4'd0 || tag !== 4'd0 || rdata !== 64'd0) begin
            failures++;
            $display("FAIL midreset_out: got resp %0d tag %0d data %h expected 0/0/0", resp, tag, rdata);
        end
        @(negedge clock);
        reset = 1'b0;
        cmd = 2'd0;
        model_reset();
        @(posedge clock); #1;
        cyc++;
        step(2'd1, 64'h80, 64'd0);
        drain();
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_single_load();
        test_store_load();
        test_back_to_back();
        test_alias_invalid();
        test_random();
        test_midflight_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
